// File: rtl/addsub_pkg.sv
// Shared types and constants for the sliced add/subtract unit.
package addsub_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_e;

  localparam logic MODE_ADD = 1'b1;
  localparam logic MODE_SUB = 1'b0;

  // Slicing is only meaningful when SLICE evenly tiles WIDTH.
  function automatic bit slice_ok(input int width, input int slice);
    return (slice >= 1) && (slice <= width) && ((width % slice) == 0);
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// Combinational SLICE-bit ripple adder stage, reused on every compute cycle.
module addsub_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] x,
  input  logic [SLICE-1:0] y,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             cout
);

  logic [SLICE:0] total_s;

  assign total_s = {1'b0, x} + {1'b0, y} + {{SLICE{1'b0}}, cin};
  assign s       = total_s[SLICE-1:0];
  assign cout    = total_s[SLICE];

endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle add/subtract: SLICE bits per clock with the carry rippled between
// cycles, cs/ready handshake, registered result, flags and a done strobe.
module addsub_seq
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cs,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             done,
  output logic             ready
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  if (!slice_ok(WIDTH, SLICE)) begin : g_bad_slice
    $error("addsub_seq: SLICE must divide WIDTH and lie in 1..WIDTH");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic             carry_q, carry_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;

  logic [SLICE-1:0] x_s, y_s, s_s;
  logic             cout_s;

  // c_q carries cin into slice 0, then each slice's carry-out into the next.
  assign x_s = a_q[cnt_q*SLICE +: SLICE];
  assign y_s = b_q[cnt_q*SLICE +: SLICE];

  addsub_slice #(.SLICE(SLICE)) u_slice (
    .x    (x_s),
    .y    (y_s),
    .cin  (c_q),
    .s    (s_s),
    .cout (cout_s)
  );

  // Next-state, datapath and flag logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    c_d        = c_q;
    part_d     = part_q;
    sum_d      = sum_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;
    done_d     = 1'b0;
    ready_d    = ready_q;
    case (state_q)
      IDLE: begin
        if (cs) begin
          a_d     = a;
          b_d     = (mode == MODE_ADD) ? b : ~b;
          c_d     = (mode == MODE_SUB);
          part_d  = '0;
          cnt_d   = '0;
          ready_d = 1'b0;
          state_d = CALC;
        end else begin
          ready_d = 1'b1;
        end
      end
      CALC: begin
        part_d[cnt_q*SLICE +: SLICE] = s_s;
        c_d = cout_s;
        if (cnt_q == LAST) begin
          sum_d      = part_d;
          carry_d    = cout_s;
          overflow_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (part_d[WIDTH-1] != a_q[WIDTH-1]);
          zero_d     = (part_d == '0);
          done_d     = 1'b1;
          ready_d    = 1'b1;
          cnt_d      = '0;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        ready_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= 1'b0;
      part_q     <= '0;
      sum_q      <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      part_q     <= part_d;
      sum_q      <= sum_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
    end
  end

  assign sum      = sum_q;
  assign carry    = carry_q;
  assign overflow = overflow_q;
  assign zero     = zero_q;
  assign done     = done_q;
  assign ready    = ready_q;

endmodule

// File: tb/tb_addsub_seq.sv
// Randomised self-checking bench for addsub_seq (16/4 and 16/16 instances)
// against an integer-arithmetic reference model.
module tb_addsub_seq;

  logic        clk, rst, cs, cs16, mode;
  logic [15:0] a, b;
  logic [15:0] sum, sum16;
  logic        carry, overflow, zero, done, ready;
  logic        carry16, overflow16, zero16, done16, ready16;

  int checks = 0;
  int errors = 0;

  addsub_seq #(.WIDTH(16), .SLICE(4)) dut (
    .clk(clk), .rst(rst), .cs(cs), .mode(mode), .a(a), .b(b),
    .sum(sum), .carry(carry), .overflow(overflow), .zero(zero),
    .done(done), .ready(ready)
  );

  addsub_seq #(.WIDTH(16), .SLICE(16)) dut16 (
    .clk(clk), .rst(rst), .cs(cs16), .mode(mode), .a(a), .b(b),
    .sum(sum16), .carry(carry16), .overflow(overflow16), .zero(zero16),
    .done(done16), .ready(ready16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns {carry, overflow, zero, sum} from plain integer arithmetic.
  function automatic logic [18:0] model(input logic m, input logic [15:0] x, input logic [15:0] y);
    int ua, ub, sa, sb, ures, sres;
    logic c, v, z;
    logic [15:0] s;
    ua = x; ub = y;
    sa = $signed(x); sb = $signed(y);
    if (m) begin
      ures = ua + ub; sres = sa + sb; c = (ures > 65535);
    end else begin
      ures = ua - ub; sres = sa - sb; c = (ua >= ub);
    end
    s = ures[15:0];
    v = (sres > 32767) || (sres < -32768);
    z = (s == 16'h0000);
    return {c, v, z, s};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepts one operation on the 16/4 instance and waits for done.
  task automatic run_op(input logic m, input logic [15:0] x, input logic [15:0] y,
                        output int lat, output int rdy_bad);
    mode = m; a = x; b = y; cs = 1'b1;
    tick();
    cs = 1'b0;
    lat = -1;
    rdy_bad = (ready !== 1'b0) ? 1 : 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (done === 1'b1) begin
        lat = n;
        if (ready !== 1'b1) rdy_bad++;
        break;
      end else if (ready !== 1'b0) begin
        rdy_bad++;
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({ready, done, sum, carry, overflow, zero} !== {1'b1, 1'b0, 16'h0000, 3'b000}) begin
      errors++;
      $display("FAIL reset_state got rdy=%b done=%b sum=%h flags=%b exp rdy=1 done=0 sum=0000 flags=000",
               ready, done, sum, {carry, overflow, zero});
    end
    checks++;
    if ({ready16, done16, sum16, carry16, overflow16, zero16} !== {1'b1, 1'b0, 16'h0000, 3'b000}) begin
      errors++;
      $display("FAIL reset_state16 got rdy=%b done=%b sum=%h exp rdy=1 done=0 sum=0000", ready16, done16, sum16);
    end
    tick();
    rst = 1'b0;
    repeat (3) tick();
    checks++;
    if ({ready, done} !== 2'b10) begin
      errors++;
      $display("FAIL reset_idle got rdy/done=%b exp 10", {ready, done});
    end
  endtask

  task automatic test_arith();
    logic [15:0] va [6] = '{16'h1234, 16'h0005, 16'h0007, 16'h7FFF, 16'h8000, 16'hFFFF};
    logic [15:0] vb [6] = '{16'h0FF0, 16'h0007, 16'h0005, 16'h0001, 16'h0001, 16'h0001};
    logic        vm [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [18:0] exp;
    logic        m;
    logic [15:0] x, y;
    int lat, rb;
    for (int i = 0; i < 36; i++) begin
      if (i < 6) begin
        m = vm[i]; x = va[i]; y = vb[i];
      end else begin
        m = 1'($urandom); x = 16'($urandom); y = 16'($urandom);
        if (i % 9 == 0) y = x;
      end
      exp = model(m, x, y);
      run_op(m, x, y, lat, rb);
      checks++;
      if (lat !== 4) begin
        errors++;
        $display("FAIL arith_latency op%0d got %0d exp 4", i, lat);
      end
      checks++;
      if (rb !== 0) begin
        errors++;
        $display("FAIL arith_ready op%0d got %0d bad samples exp 0", i, rb);
      end
      checks++;
      if (sum !== exp[15:0]) begin
        errors++;
        $display("FAIL arith_sum op%0d m=%b a=%h b=%h got %h exp %h", i, m, x, y, sum, exp[15:0]);
      end
      checks++;
      if ({carry, overflow, zero} !== exp[18:16]) begin
        errors++;
        $display("FAIL arith_flags op%0d m=%b a=%h b=%h got cvz=%b exp %b", i, m, x, y,
                 {carry, overflow, zero}, exp[18:16]);
      end
      tick();
      checks++;
      if (done !== 1'b0 || sum !== exp[15:0]) begin
        errors++;
        $display("FAIL done_strobe op%0d got done=%b sum=%h exp done=0 sum=%h", i, done, sum, exp[15:0]);
      end
    end
  endtask

  task automatic test_busy_ignore();
    logic [18:0] exp;
    int extra;
    exp = model(1'b1, 16'h1111, 16'h2222);
    mode = 1'b1; a = 16'h1111; b = 16'h2222; cs = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      cs = (k < 2); a = 16'($urandom); b = 16'($urandom); mode = 1'($urandom);
      tick();
    end
    cs = 1'b0;
    tick();
    checks++;
    if (done !== 1'b1 || sum !== exp[15:0]) begin
      errors++;
      $display("FAIL busy_result got done=%b sum=%h exp done=1 sum=%h", done, sum, exp[15:0]);
    end
    extra = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (done !== 1'b0 || ready !== 1'b1) extra++;
    end
    checks++;
    if (extra !== 0 || sum !== exp[15:0]) begin
      errors++;
      $display("FAIL busy_no_extra got %0d busy/done samples sum=%h exp 0 sum=%h", extra, sum, exp[15:0]);
    end
  endtask

  task automatic test_reset_mid();
    int lat, rb, dcount;
    run_op(1'b1, 16'h1234, 16'h0FF0, lat, rb);
    mode = 1'b1; a = 16'h4321; b = 16'h1111; cs = 1'b1;
    tick();
    cs = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({ready, done, sum, carry, overflow, zero} !== {1'b1, 1'b0, 16'h0000, 3'b000}) begin
      errors++;
      $display("FAIL reset_mid got rdy=%b done=%b sum=%h flags=%b exp rdy=1 done=0 sum=0000 flags=000",
               ready, done, sum, {carry, overflow, zero});
    end
    tick();
    rst = 1'b0;
    dcount = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (done === 1'b1) dcount++;
    end
    checks++;
    if (dcount !== 0 || ready !== 1'b1 || sum !== 16'h0000) begin
      errors++;
      $display("FAIL reset_discard got dones=%0d rdy=%b sum=%h exp 0 1 0000", dcount, ready, sum);
    end
  endtask

  task automatic test_back_to_back();
    logic        om [4];
    logic [15:0] ox [4], oy [4];
    logic [18:0] exp;
    int k, prev;
    for (int i = 0; i < 4; i++) begin
      om[i] = 1'($urandom); ox[i] = 16'($urandom); oy[i] = 16'($urandom);
    end
    k = 0; prev = 0;
    mode = om[0]; a = ox[0]; b = oy[0]; cs = 1'b1;
    tick();
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (done === 1'b1) begin
        exp = model(om[k], ox[k], oy[k]);
        checks++;
        if (sum !== exp[15:0] || {carry, overflow, zero} !== exp[18:16]) begin
          errors++;
          $display("FAIL b2b_result op%0d got sum=%h cvz=%b exp sum=%h cvz=%b", k, sum,
                   {carry, overflow, zero}, exp[15:0], exp[18:16]);
        end
        checks++;
        if ((n - prev) !== ((k == 0) ? 4 : 5)) begin
          errors++;
          $display("FAIL b2b_interval op%0d got %0d exp %0d", k, n - prev, (k == 0) ? 4 : 5);
        end
        prev = n;
        k++;
        if (k < 4) begin
          mode = om[k]; a = ox[k]; b = oy[k];
        end else begin
          cs = 1'b0;
          break;
        end
      end
    end
    cs = 1'b0;
    checks++;
    if (k !== 4) begin
      errors++;
      $display("FAIL b2b_count got %0d exp 4", k);
    end
    repeat (6) tick();
  endtask

  task automatic test_slice16();
    logic [18:0] exp;
    logic        m;
    logic [15:0] x, y;
    cs = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin
        m = 1'b1; x = 16'h1234; y = 16'h0FF0;
      end else begin
        m = 1'($urandom); x = 16'($urandom); y = 16'($urandom);
      end
      exp = model(m, x, y);
      mode = m; a = x; b = y; cs16 = 1'b1;
      tick();
      cs16 = 1'b0;
      checks++;
      if (ready16 !== 1'b0 || done16 !== 1'b0) begin
        errors++;
        $display("FAIL s16_busy op%0d got rdy=%b done=%b exp 0 0", i, ready16, done16);
      end
      tick();
      checks++;
      if (done16 !== 1'b1 || ready16 !== 1'b1 || sum16 !== exp[15:0] ||
          {carry16, overflow16, zero16} !== exp[18:16]) begin
        errors++;
        $display("FAIL s16_result op%0d got done=%b rdy=%b sum=%h cvz=%b exp 1 1 %h %b", i, done16,
                 ready16, sum16, {carry16, overflow16, zero16}, exp[15:0], exp[18:16]);
      end
      tick();
      checks++;
      if (done16 !== 1'b0) begin
        errors++;
        $display("FAIL s16_strobe op%0d got done=%b exp 0", i, done16);
      end
    end
  endtask

  initial begin
    rst = 1'b1; cs = 1'b0; cs16 = 1'b0; mode = 1'b1; a = 16'h0000; b = 16'h0000;
    #2;
    test_reset();
    test_arith();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    test_slice16();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
